mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Purpose : arbitrates one synchronous memory port between an external loader and the CPU fetch/decode path.
// Latency : 1 cycle from an accepted loader beat or CPU request to the registered mem_we/mem_addr/mem_din.
// Backpressure: the loader is held off with ld_ready=0 outside LOAD; the CPU is held with cpu_stall=1 outside CPU.
//
// Ports:
//   clk, reset                      : single clock, asynchronous active-high reset
//   ld_req/ld_valid/ld_we/ld_addr/ld_wdata/ld_done : loader request, beat and release
//   ld_ready                        : loader beat accepted when high together with ld_valid
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_boundary : CPU request and instruction-boundary hint
//   cpu_grant/cpu_stall             : CPU owns the bus / CPU must hold
//   mem_we/mem_addr/mem_din/mem_dout: registered memory port, 1-cycle synchronous read data
//   rdata                           : mem_dout forwarded to the current owner
//   state/beat_cnt/load_err         : FSM state, beats accepted since LOAD entry, sticky verify error
//
// Optional feature: define MEM_ARB_VERIFY_EN to read back and compare every loader write
// (LOAD -> VRD -> VCMP -> LOAD/IDLE). Without it VRD/VCMP are unreachable and load_err is 0.

module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ld_req,
    input  logic                  ld_valid,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    input  logic                  ld_done,
    output logic                  ld_ready,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_boundary,
    output logic                  cpu_grant,
    output logic                  cpu_stall,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] rdata,

    output logic [2:0]            state,
    output logic [ADDR_WIDTH-1:0] beat_cnt,
    output logic                  load_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CPU  = 3'd2,
        S_VRD  = 3'd3,
        S_VCMP = 3'd4
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   beat_acc;
    logic   load_entry;

`ifdef MEM_ARB_VERIFY_EN
    logic                  vrd_hold;   // first VRD cycle: the write is still on the port
    logic                  done_seen;  // ld_done observed while a verify was in flight
    logic [DATA_WIDTH-1:0] vfy_data;   // data of the write being verified
    logic                  err_q;
    logic                  cmp_err;
`endif

    // The loader is only accepted in LOAD; during verify it is held off.
    assign ld_ready   = (cur_state == S_LOAD);
    assign beat_acc   = ld_ready & ld_valid;
    assign rdata      = mem_dout;
    assign state      = cur_state;
    assign load_entry = (nxt_state == S_LOAD) &&
                        ((cur_state == S_IDLE) || (cur_state == S_CPU));

`ifdef MEM_ARB_VERIFY_EN
    // Mismatch is reported during VCMP itself and then latched.
    assign cmp_err  = (cur_state == S_VCMP) && (mem_dout != vfy_data);
    assign load_err = err_q | cmp_err;
`else
    assign load_err = 1'b0;
`endif

    always_comb begin
        nxt_state = S_IDLE;
        case (cur_state)
            S_IDLE: begin
                // Loader wins a simultaneous request.
                if (ld_req)       nxt_state = S_LOAD;
                else if (cpu_req) nxt_state = S_CPU;
                else              nxt_state = S_IDLE;
            end
            S_LOAD: begin
`ifdef MEM_ARB_VERIFY_EN
                if (beat_acc && ld_we) nxt_state = S_VRD;
                else if (ld_done)      nxt_state = S_IDLE;
                else                   nxt_state = S_LOAD;
`else
                // A beat accepted alongside ld_done is still issued next cycle.
                if (ld_done) nxt_state = S_IDLE;
                else         nxt_state = S_LOAD;
`endif
            end
            S_CPU: begin
                // The loader only preempts the CPU at an instruction boundary.
                if (!cpu_req)                    nxt_state = S_IDLE;
                else if (ld_req && cpu_boundary) nxt_state = S_LOAD;
                else                             nxt_state = S_CPU;
            end
`ifdef MEM_ARB_VERIFY_EN
            S_VRD: begin
                nxt_state = vrd_hold ? S_VRD : S_VCMP;
            end
            S_VCMP: begin
                nxt_state = (done_seen || ld_done) ? S_IDLE : S_LOAD;
            end
`endif
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_IDLE;
            cpu_grant <= 1'b0;
            cpu_stall <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            beat_cnt  <= '0;
`ifdef MEM_ARB_VERIFY_EN
            vrd_hold  <= 1'b0;
            done_seen <= 1'b0;
            vfy_data  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            cur_state <= nxt_state;
            cpu_grant <= (nxt_state == S_CPU);
            cpu_stall <= (nxt_state != S_CPU);
            mem_we    <= 1'b0;

            if (load_entry) begin
                beat_cnt <= '0;
`ifdef MEM_ARB_VERIFY_EN
                err_q    <= 1'b0;
`endif
            end

            case (cur_state)
                S_LOAD: begin
                    if (beat_acc) begin
                        mem_we   <= ld_we;
                        mem_addr <= ld_addr;
                        mem_din  <= ld_wdata;
                        beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
`ifdef MEM_ARB_VERIFY_EN
                        if (ld_we) begin
                            vrd_hold  <= 1'b1;
                            done_seen <= ld_done;
                            vfy_data  <= ld_wdata;
                        end
`endif
                    end
                end
                S_CPU: begin
                    if (cpu_req) begin
                        mem_we   <= cpu_we;
                        mem_addr <= cpu_addr;
                        mem_din  <= cpu_wdata;
                    end
                end
`ifdef MEM_ARB_VERIFY_EN
                S_VRD: begin
                    // mem_addr still holds the written address; mem_we stays low for the read.
                    vrd_hold <= 1'b0;
                    if (ld_done) done_seen <= 1'b1;
                end
                S_VCMP: begin
                    if (cmp_err) err_q <= 1'b1;
                    done_seen <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small synchronous memory model.
// Narrow address width keeps the beat counter wrap test short.

module tb_mem_bus_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_req, ld_valid, ld_we, ld_done, ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          cpu_req, cpu_we, cpu_boundary, cpu_grant, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] rdata;
    logic [2:0]    state;
    logic [AW-1:0] beat_cnt;
    logic          load_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_req       (ld_req),
        .ld_valid     (ld_valid),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .ld_done      (ld_done),
        .ld_ready     (ld_ready),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_boundary (cpu_boundary),
        .cpu_grant    (cpu_grant),
        .cpu_stall    (cpu_stall),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .rdata        (rdata),
        .state        (state),
        .beat_cnt     (beat_cnt),
        .load_err     (load_err)
    );

    // Synchronous memory, 1-cycle read; optionally corrupts writes to 0x02.
    logic [DW-1:0] mem [256];
    logic          corrupt_en;
    int            we_cnt = 0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= (corrupt_en && mem_addr == 8'h02) ? 8'hFF : mem_din;
            we_cnt <= we_cnt + 1;
        end
        mem_dout <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},    32'(state),    32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_din"},  32'(mem_din),  32'd0);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        check({tag, "_grant"},    32'(cpu_grant), 32'd0);
        check({tag, "_stall"},    32'(cpu_stall), 32'd1);
        check({tag, "_beat_cnt"}, 32'(beat_cnt), 32'd0);
        check({tag, "_load_err"}, 32'(load_err), 32'd0);
    endtask

    logic [7:0] ld_tbl [4] = '{8'hA9, 8'h04, 8'h85, 8'h02};
    int cnt0;

    initial begin
        reset = 1'b1;
        ld_req = 0; ld_valid = 0; ld_we = 0; ld_done = 0;
        ld_addr = '0; ld_wdata = '0;
        cpu_req = 0; cpu_we = 0; cpu_boundary = 0;
        cpu_addr = '0; cpu_wdata = '0;
        corrupt_en = 0;

        // Reset state
        step();
        step();
        check_reset_values("rst");
        reset = 1'b0;

        // Simultaneous requests in IDLE: loader wins
        ld_req = 1; cpu_req = 1;
        step();
        check("arb_state", 32'(state), 32'd1);
        check("arb_stall", 32'(cpu_stall), 32'd1);
        check("arb_grant", 32'(cpu_grant), 32'd0);
        check("arb_ld_ready", 32'(ld_ready), 32'd1);
        check("arb_beat_cnt", 32'(beat_cnt), 32'd0);
        cpu_req = 0;

`ifndef MEM_ARB_VERIFY_EN
        // Four write beats at 0x10..0x13, then ld_done
        cnt0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_we = 1;
            ld_addr = 8'(16 + i); ld_wdata = ld_tbl[i];
            step();
            check("ld_mem_we",   32'(mem_we),   32'd1);
            check("ld_mem_addr", 32'(mem_addr), 32'(16 + i));
            check("ld_mem_din",  32'(mem_din),  32'(ld_tbl[i]));
            check("ld_beat_cnt", 32'(beat_cnt), 32'(i + 1));
        end
        ld_valid = 0; ld_we = 0; ld_done = 1; ld_req = 0;
        step();
        check("ld_done_state", 32'(state), 32'd0);
        check("ld_done_mem_we", 32'(mem_we), 32'd0);
        check("ld_done_beat_cnt", 32'(beat_cnt), 32'd4);
        check("ld_we_pulses", 32'(we_cnt - cnt0), 32'd4);
        check("ld_mem_0x12", 32'(mem[8'h12]), 32'h85);
        check("ld_mem_0x13", 32'(mem[8'h13]), 32'h02);
        ld_done = 0;

        // Read beat, then a write beat together with ld_done
        ld_req = 1;
        step();
        check("ld2_state", 32'(state), 32'd1);
        check("ld2_beat_cnt", 32'(beat_cnt), 32'd0);
        ld_req = 0;
        ld_valid = 1; ld_we = 0; ld_addr = 8'h31; ld_wdata = 8'h11;
        step();
        check("rd_beat_mem_we", 32'(mem_we), 32'd0);
        check("rd_beat_addr", 32'(mem_addr), 32'h31);
        check("rd_beat_cnt", 32'(beat_cnt), 32'd1);
        ld_we = 1; ld_addr = 8'h30; ld_wdata = 8'h77; ld_done = 1;
        step();
        check("done_beat_state", 32'(state), 32'd0);
        check("done_beat_mem_we", 32'(mem_we), 32'd1);
        check("done_beat_addr", 32'(mem_addr), 32'h30);
        check("done_beat_din", 32'(mem_din), 32'h77);
        check("done_beat_cnt", 32'(beat_cnt), 32'd2);
        ld_valid = 0; ld_we = 0; ld_done = 0;
        step();
        check("done_beat_we_off", 32'(mem_we), 32'd0);
`else
        // Readback verify with a memory that corrupts address 0x02
        corrupt_en = 1;
        ld_valid = 1; ld_we = 1; ld_addr = 8'h02; ld_wdata = 8'h04;
        step();
        check("vfy_vrd_state", 32'(state), 32'd3);
        check("vfy_wr_pulse", 32'(mem_we), 32'd1);
        check("vfy_vrd_ready", 32'(ld_ready), 32'd0);
        ld_valid = 0; ld_we = 0;
        step();
        check("vfy_vrd2_state", 32'(state), 32'd3);
        check("vfy_rd_we", 32'(mem_we), 32'd0);
        check("vfy_rd_addr", 32'(mem_addr), 32'h02);
        step();
        check("vfy_vcmp_state", 32'(state), 32'd4);
        check("vfy_vcmp_err", 32'(load_err), 32'd1);
        step();
        check("vfy_back_load", 32'(state), 32'd1);
        check("vfy_err_held", 32'(load_err), 32'd1);
        ld_req = 0; ld_done = 1;
        step();
        check("vfy_idle", 32'(state), 32'd0);
        check("vfy_err_idle", 32'(load_err), 32'd1);
        ld_done = 0; ld_req = 1;
        step();
        check("vfy_reload", 32'(state), 32'd1);
        check("vfy_err_clear", 32'(load_err), 32'd0);
        ld_req = 0; ld_done = 1;
        step();
        check("vfy_idle2", 32'(state), 32'd0);
        ld_done = 0; corrupt_en = 0;
`endif

        // CPU ownership and boundary-gated preemption
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h5A;
        step();
        check("cpu_state", 32'(state), 32'd2);
        check("cpu_grant", 32'(cpu_grant), 32'd1);
        check("cpu_stall", 32'(cpu_stall), 32'd0);
        check("cpu_ld_ready", 32'(ld_ready), 32'd0);
        check("cpu_first_we", 32'(mem_we), 32'd0);
        step();
        check("cpu_wr_we", 32'(mem_we), 32'd1);
        check("cpu_wr_addr", 32'(mem_addr), 32'h20);
        check("cpu_wr_din", 32'(mem_din), 32'h5A);
        cpu_we = 0; ld_req = 1; cpu_boundary = 0;
        step();
        check("cpu_nb1_state", 32'(state), 32'd2);
        check("cpu_rd_we", 32'(mem_we), 32'd0);
        step();
        check("cpu_nb2_state", 32'(state), 32'd2);
        step();
        check("cpu_nb3_state", 32'(state), 32'd2);
        check("cpu_rdata", 32'(rdata), 32'h5A);
        cpu_boundary = 1;
        step();
        check("cpu_pre_state", 32'(state), 32'd1);
        check("cpu_pre_grant", 32'(cpu_grant), 32'd0);
        check("cpu_pre_stall", 32'(cpu_stall), 32'd1);
        check("cpu_pre_cnt", 32'(beat_cnt), 32'd0);
        ld_req = 0; cpu_req = 0; cpu_boundary = 0;

        // Beat counter wrap: 2^AW + 1 read beats
        ld_valid = 1; ld_we = 0; ld_addr = 8'h50;
        repeat (256) step();
        check("wrap_cnt_0", 32'(beat_cnt), 32'd0);
        step();
        check("wrap_cnt_1", 32'(beat_cnt), 32'd1);
        ld_valid = 0; ld_done = 1;
        step();
        check("wrap_idle", 32'(state), 32'd0);
        ld_done = 0;

        // Reset in the middle of a loader write
        ld_req = 1;
        step();
        ld_req = 0;
        ld_valid = 1; ld_we = 1; ld_addr = 8'h40; ld_wdata = 8'h99;
        step();
        check("mid_pre_we", 32'(mem_we), 32'd1);
        cnt0 = we_cnt;
        reset = 1;
        #1;
        check_reset_values("mid_rst");
        step();
        check("mid_rst_no_write", 32'(we_cnt - cnt0), 32'd0);
        step();
        reset = 0; ld_valid = 0; ld_we = 0;
        step();
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_we", 32'(mem_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
